// File: rtl/ecg_bit_packer.sv
// ecg_bit_packer
//   Packs variable-length entropy-encoder groups (encoded field followed by
//   sign field, each MSB first) into a contiguous bitstream of 32-bit words.
//   The first bit in time lands at out_word[31]. A flush pulse drains the
//   accumulator and zero-pads the final partial word, marking it with out_last.
//
// Configuration macro:
//   PACKER_BITCOUNT_EN - adds the total_bits output, a running count of the
//                        bits taken from accepted groups (cleared on reset and
//                        when a flush completes).
//
// Ports:
//   clk                 clock, all state updates on the rising edge
//   rst                 asynchronous active-low reset
//   in_valid/in_ready   group handshake
//   encoded_ECG         encoded group, valid bits [sizeof_encoded_ECG-1:0]
//   sizeof_encoded_ECG  0..50
//   sign_bits           sign bits, valid bits [sizeof_sign_bits-1:0]
//   sizeof_sign_bits    0..4
//   flush               single-cycle drain request
//   out_word/out_valid  packed word handshake with out_ready
//   out_last            final (padded) word of a flush
//   flush_done          one-cycle pulse when a flush has completed
//   overflow_err        sticky, set by an out-of-range input size
//   total_bits          (PACKER_BITCOUNT_EN only) accepted bit count
//
// States:
//   RUN   | normal packing, groups accepted
//   FLUSH | no new groups, full words drain
//   LAST  | emit the zero-padded tail word and wait for it to be taken
//   DONE  | pulse flush_done, clear the accumulator, return to RUN

module ecg_bit_packer #(
  parameter int ACC_WIDTH  = 128,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [49:0]           encoded_ECG,
  input  logic [6:0]            sizeof_encoded_ECG,
  input  logic [3:0]            sign_bits,
  input  logic [2:0]            sizeof_sign_bits,
  input  logic                  flush,
  output logic [WORD_WIDTH-1:0] out_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  flush_done,
  output logic                  overflow_err
`ifdef PACKER_BITCOUNT_EN
  ,
  output logic [31:0]           total_bits
`endif
);

  // Widest possible group: 50 encoded bits plus 4 sign bits.
  localparam int GW = 54;
  localparam int FW = $clog2(ACC_WIDTH + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    LAST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [ACC_WIDTH-1:0]  acc, acc_nx;
  logic [FW-1:0]         fill, fill_nx;
  logic [WORD_WIDTH-1:0] word_nx;
  logic                  valid_nx, last_nx, ovf_nx;

  // Group decode
  logic          size_ok;
  logic          accept;
  logic          take_bits;
  logic [5:0]    grp_bits;
  logic [GW-1:0] ecg_mask, sgn_mask, grp_val;

  // Merged view: accumulator with the incoming group already appended, so a
  // group that completes a word can be emitted in the cycle it is accepted.
  logic [FW-1:0]        add_bits, m_fill, place_sh;
  logic [ACC_WIDTH-1:0] m_acc;
  logic                 out_free;

  always_comb begin
    size_ok  = (sizeof_encoded_ECG <= 7'd50) && (sizeof_sign_bits <= 3'd4);
    ecg_mask = (GW'(1) << sizeof_encoded_ECG) - GW'(1);
    sgn_mask = (GW'(1) << sizeof_sign_bits) - GW'(1);
    grp_val  = (({4'd0, encoded_ECG} & ecg_mask) << sizeof_sign_bits)
             | ({50'd0, sign_bits} & sgn_mask);
    grp_bits = size_ok ? (sizeof_encoded_ECG[5:0] + {3'd0, sizeof_sign_bits}) : 6'd0;
  end

  assign in_ready  = (state == RUN) && (fill <= FW'(ACC_WIDTH - GW)) && !flush;
  assign accept    = in_valid && in_ready;
  // Oversized groups are consumed by the handshake but contribute no bits.
  assign take_bits = accept && size_ok;
  assign out_free  = !out_valid || out_ready;

  always_comb begin
    add_bits = take_bits ? FW'(grp_bits) : '0;
    m_fill   = fill + add_bits;
    // New bits sit directly below the current fill, so the group's LSB lands
    // at position ACC_WIDTH - fill - n. in_ready guarantees this is >= 0.
    place_sh = FW'(ACC_WIDTH) - m_fill;
    m_acc    = acc;
    if (take_bits) begin
      m_acc = acc | ({{(ACC_WIDTH-GW){1'b0}}, grp_val} << place_sh);
    end
  end

  always_comb begin
    state_nx   = state;
    acc_nx     = m_acc;
    fill_nx    = m_fill;
    word_nx    = out_word;
    valid_nx   = out_valid;
    last_nx    = out_last;
    ovf_nx     = overflow_err | (accept && !size_ok);
    flush_done = 1'b0;

    if (out_valid && out_ready) begin
      valid_nx = 1'b0;
      last_nx  = 1'b0;
    end

    case (state)
      RUN: begin
        if (m_fill >= FW'(WORD_WIDTH) && out_free) begin
          word_nx  = m_acc[ACC_WIDTH-1 -: WORD_WIDTH];
          valid_nx = 1'b1;
          last_nx  = 1'b0;
          acc_nx   = m_acc << WORD_WIDTH;
          fill_nx  = m_fill - FW'(WORD_WIDTH);
        end
        if (flush) begin
          state_nx = FLUSH;
        end
      end

      FLUSH: begin
        if (m_fill >= FW'(WORD_WIDTH)) begin
          if (out_free) begin
            word_nx  = m_acc[ACC_WIDTH-1 -: WORD_WIDTH];
            valid_nx = 1'b1;
            last_nx  = 1'b0;
            acc_nx   = m_acc << WORD_WIDTH;
            fill_nx  = m_fill - FW'(WORD_WIDTH);
          end
        end else if (m_fill != '0) begin
          state_nx = LAST;
        end else if (out_free) begin
          // Nothing left to pad: finish once the last full word has gone.
          state_nx = DONE;
        end
      end

      LAST: begin
        if (fill != '0) begin
          // Bits below the fill are always zero, so the top word is already
          // right-padded.
          if (out_free) begin
            word_nx  = acc[ACC_WIDTH-1 -: WORD_WIDTH];
            valid_nx = 1'b1;
            last_nx  = 1'b1;
            acc_nx   = '0;
            fill_nx  = '0;
          end
        end else if (out_valid && out_ready) begin
          state_nx = DONE;
        end
      end

      DONE: begin
        flush_done = 1'b1;
        acc_nx     = '0;
        fill_nx    = '0;
        state_nx   = RUN;
      end

      default: begin
        state_nx = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      acc          <= '0;
      fill         <= '0;
      out_word     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state        <= state_nx;
      acc          <= acc_nx;
      fill         <= fill_nx;
      out_word     <= word_nx;
      out_valid    <= valid_nx;
      out_last     <= last_nx;
      overflow_err <= ovf_nx;
    end
  end

`ifdef PACKER_BITCOUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_bits <= '0;
    end else if (state == DONE) begin
      total_bits <= '0;
    end else if (take_bits) begin
      total_bits <= total_bits + 32'(grp_bits);
    end
  end
`endif

endmodule

// File: tb/tb_ecg_bit_packer.sv
module tb_ecg_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [49:0] encoded_ECG;
  logic [6:0]  sizeof_encoded_ECG;
  logic [3:0]  sign_bits;
  logic [2:0]  sizeof_sign_bits;
  logic        flush;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        flush_done;
  logic        overflow_err;
`ifdef PACKER_BITCOUNT_EN
  logic [31:0] total_bits;
`endif

  always #5 clk = ~clk;

  ecg_bit_packer dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .encoded_ECG        (encoded_ECG),
    .sizeof_encoded_ECG (sizeof_encoded_ECG),
    .sign_bits          (sign_bits),
    .sizeof_sign_bits   (sizeof_sign_bits),
    .flush              (flush),
    .out_word           (out_word),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_last           (out_last),
    .flush_done         (flush_done),
    .overflow_err       (overflow_err)
`ifdef PACKER_BITCOUNT_EN
    ,
    .total_bits         (total_bits)
`endif
  );

  // Reference model: the bitstream as a plain queue of bits in time order.
  bit          model_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_word;
  logic        prev_last;
  int          words_seen;
  logic [31:0] last_word;
  logic        last_flag;
  bit          done_seen;
  bit          last_acc;

  typedef struct {
    logic [49:0] ecg;
    int          esz;
    logic [3:0]  sgn;
    int          ssz;
    bit          has_word;
    logic [31:0] word;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_group(input logic [49:0] e, input int es, input logic [3:0] s, input int ss);
    encoded_ECG        = e;
    sizeof_encoded_ECG = 7'(es);
    sign_bits          = s;
    sizeof_sign_bits   = 3'(ss);
  endtask

  // Called at a falling edge with inputs already driven; samples, checks any
  // word consumed at the next rising edge, updates the model, and returns at
  // the following falling edge.
  task automatic tick();
    logic [31:0] exp_w;
    int          k;
    #1;
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_word", out_word, prev_word);
      check("hold_last", 32'(out_last), 32'(prev_last));
    end
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      words_seen++;
      last_word = out_word;
      last_flag = out_last;
      if (model_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_word: got %h with no bits expected", out_word);
      end else begin
        k = (model_q.size() < 32) ? model_q.size() : 32;
        exp_w = '0;
        for (int j = 0; j < k; j++) exp_w[31-j] = model_q.pop_front();
        check("word", out_word, exp_w);
        check("last", 32'(out_last), 32'(k < 32));
      end
    end
    if (flush_done) done_seen = 1'b1;
    prev_stall = out_valid && !out_ready;
    prev_word  = out_word;
    prev_last  = out_last;
    if (last_acc && sizeof_encoded_ECG <= 7'd50 && sizeof_sign_bits <= 3'd4) begin
      for (int j = int'(sizeof_encoded_ECG) - 1; j >= 0; j--) model_q.push_back(encoded_ECG[j]);
      for (int j = int'(sizeof_sign_bits) - 1; j >= 0; j--) model_q.push_back(sign_bits[j]);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_word"}, out_word, 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_flush_done"}, 32'(flush_done), 32'd0);
    check({tag, "_overflow"}, 32'(overflow_err), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_flush(output int nw);
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    flush      = 1'b1;
    words_seen = 0;
    done_seen  = 1'b0;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) tick();
    check("flush_done_seen", 32'(done_seen), 32'd1);
    check("model_empty", 32'(model_q.size()), 32'd0);
    nw = words_seen;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    int n_acc;
    int es;

    vt[0] = '{50'h2AB,             10, 4'h0, 0, 1'b1, 32'hAAC00000};
    vt[1] = '{50'h3,                2, 4'h5, 3, 1'b1, 32'hE8000000};
    vt[2] = '{50'h3FFFFFFFFFFFF,    4, 4'hF, 0, 1'b1, 32'hF0000000};
    vt[3] = '{50'h0,                0, 4'hA, 4, 1'b1, 32'hA0000000};
    vt[4] = '{50'h1,                1, 4'hE, 1, 1'b1, 32'h80000000};
    vt[5] = '{50'h3FFFFFFFFFFFF,    0, 4'hF, 0, 1'b0, 32'h00000000};
    vt[6] = '{50'h12345,           17, 4'h9, 4, 1'b1, 32'h91A2C800};
    vt[7] = '{50'h7FFFFFFF,        31, 4'h0, 0, 1'b1, 32'hFFFFFFFE};

    rst       = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    set_group(50'd0, 0, 4'd0, 0);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

`ifdef PACKER_BITCOUNT_EN
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_group(50'($urandom()), 20, 4'($urandom()), 3);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("total_bits", total_bits, 32'd69);
    do_flush(nw);
    #1;
    check("total_bits_cleared", total_bits, 32'd0);
`endif

    // Single groups followed by a flush
    for (int i = 0; i < 8; i++) begin
      set_group(vt[i].ecg, vt[i].esz, vt[i].sgn, vt[i].ssz);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      do_flush(nw);
      check($sformatf("vec%0d_count", i), 32'(nw), 32'(vt[i].has_word));
      if (vt[i].has_word) begin
        check($sformatf("vec%0d_word", i), last_word, vt[i].word);
        check($sformatf("vec%0d_last", i), 32'(last_flag), 32'd1);
      end
    end

    // Two 30+2 groups: each completes a word, emitted the cycle after accept
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_group(50'h23456789, 30, 4'b0011, 2);
    tick();
    #1;
    check("pair_valid1", 32'(out_valid), 32'd1);
    check("pair_word1", out_word, 32'h8D159E27);
    set_group(50'h1ABCDEF0, 30, 4'b0001, 2);
    tick();
    #1;
    check("pair_valid2", 32'(out_valid), 32'd1);
    check("pair_word2", out_word, 32'h6AF37BC1);
    in_valid = 1'b0;
    tick();
    #1;
    check("pair_idle", 32'(out_valid), 32'd0);

    // Flush with an empty accumulator
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("empty_fd0", 32'(flush_done), 32'd0);
    check("empty_nov0", 32'(out_valid), 32'd0);
    tick();
    #1;
    check("empty_fd1", 32'(flush_done), 32'd1);
    check("empty_nov1", 32'(out_valid), 32'd0);
    tick();
    #1;
    check("empty_fd2", 32'(flush_done), 32'd0);
    check("empty_ready", 32'(in_ready), 32'd1);

    // Back-pressure with full-size groups
    out_ready = 1'b0;
    in_valid  = 1'b1;
    n_acc     = 0;
    for (int i = 0; i < 6; i++) begin
      set_group(50'({$urandom(), $urandom()}), 50, 4'($urandom()), 4);
      tick();
      if (last_acc) n_acc++;
    end
    check("bp_accepts", 32'(n_acc), 32'd2);
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    do_flush(nw);
    check("bp_words", 32'(nw), 32'd4);

    // Oversized groups are dropped and flag overflow
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_group(50'h2AB, 10, 4'h0, 0);
    tick();
    set_group(50'h3FFFF, 55, 4'hF, 2);
    tick();
    #1;
    check("ovf_set", 32'(overflow_err), 32'd1);
    check("ovf_ready", 32'(in_ready), 32'd1);
    set_group(50'h0, 0, 4'hF, 5);
    tick();
    do_flush(nw);
    check("ovf_words", 32'(nw), 32'd1);
    check("ovf_word", last_word, 32'hAAC00000);
    check("ovf_sticky", 32'(overflow_err), 32'd1);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_group(50'({$urandom(), $urandom()}), 50, 4'($urandom()), 4);
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_q.delete();
    prev_stall = 1'b0;

    // Randomized traffic against the bit-queue model
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      es = ($urandom_range(0, 49) == 0) ? int'($urandom_range(51, 127)) : int'($urandom_range(0, 50));
      set_group(50'({$urandom(), $urandom()}), es, 4'($urandom()), int'($urandom_range(0, 4)));
      tick();
    end
    do_flush(nw);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ecg_bit_packer.md
ECG_BIT_PACKER -- requirements
Module: ecg_bit_packer

Interface
REQ-001 Parameter: ACC_WIDTH, default 128; bit-accumulator width, legal range 96..256.
REQ-002 Parameter: WORD_WIDTH, fixed at 32; output word width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  entropy-encoder output group present; driven from the encoder's valid_op qualified by group timing.
REQ-006 in_ready  output  1  packer can accept a group this cycle.
REQ-007 encoded_ECG  input  50  encoded group; valid bits are [sizeof_encoded_ECG-1:0].
REQ-008 sizeof_encoded_ECG  input  7  bit count of encoded_ECG, 0..50.
REQ-009 sign_bits  input  4  sign bits; valid bits are [sizeof_sign_bits-1:0].
REQ-010 sizeof_sign_bits  input  3  bit count of sign_bits, 0..4.
REQ-011 flush  input  1  single-cycle pulse; request to drain the accumulator at slice end.
REQ-012 out_word  output  32  packed bitstream word; first bit in time sits at bit 31.
REQ-013 out_valid  output  1  out_word holds a valid word.
REQ-014 out_ready  input  1  downstream accepts out_word this cycle.
REQ-015 out_last  output  1  qualifies out_word as the final word of a flush.
REQ-016 flush_done  output  1  one-cycle pulse when a flush has fully completed.
REQ-017 overflow_err  output  1  sticky; set when an input size exceeds its legal range.

Function
REQ-018 A group is accepted in a cycle when in_valid && in_ready are both high.
REQ-019 Append order per group: encoded bits first, then sign bits; each field is sent MSB first (bit size-1 first).
REQ-020 Accumulator holds fill bits (0..ACC_WIDTH), left-aligned; new bits go directly below the existing fill.
REQ-021 in_ready = 1 only when state is RUN, fill <= ACC_WIDTH-54 and flush is low.
REQ-022 A word is emitted when fill >= 32 and the output register is empty, or is being consumed in the same cycle; out_word = top 32 accumulator bits and fill decreases by 32.
REQ-023 Latency: a group accepted in cycle N that brings fill >= 32 gives out_valid=1 in cycle N+1 at the earliest.
REQ-024 While out_valid && !out_ready, out_word, out_valid and out_last are held stable.
REQ-025 Accept and emit in the same cycle are both applied; next fill = fill + in_bits - 32.
REQ-026 An input with size 0+0 is accepted and leaves fill unchanged.
REQ-027 Sizes >50 or >4: the group is accepted but dropped, and overflow_err is set until reset.
REQ-028 FSM states: RUN, FLUSH, LAST, DONE.
REQ-029 RUN -> FLUSH on flush=1; a group presented in the same cycle is not accepted.
REQ-030 In FLUSH, full words drain normally. When fill < 32, go to LAST if fill > 0, else go to DONE.
REQ-031 In LAST, the remaining bits are zero-padded on the right to 32 and emitted with out_last=1. Go to DONE when that word is consumed.
REQ-032 DONE pulses flush_done for one cycle and returns to RUN with fill = 0.
REQ-033 A flush pulse outside RUN is ignored.

Reset
REQ-034 While rst=0: state=RUN, fill=0, accumulator=0, out_word=0, out_valid=0, out_last=0, flush_done=0, overflow_err=0, in_ready=1 (after the combinational settle).
REQ-035 Reset asserted mid-operation discards all accumulated and pending bits immediately, without waiting for a clock edge.

Configuration
REQ-036 Macro PACKER_BITCOUNT_EN defined: adds output total_bits [31:0], which counts the bits of every accepted group (wraps modulo 2^32, clears on reset and on DONE).
REQ-037 Macro PACKER_BITCOUNT_EN undefined: total_bits port and counter do not exist; all other behaviour is identical.

Verification
REQ-038 Scenario: two groups of 30+2 bits, out_ready=1 -> cycle after first accept out_valid=1 with word = group1 ECG bits then its 2 sign bits; fill=32 after second, second word emitted next cycle.
REQ-039 Scenario: out_ready=0 with continuous 50+4 groups -> in_ready drops once fill > 74; out_word stays stable; no bits lost after out_ready is raised.
REQ-040 Scenario: 10 bits (0x2AB, size 10) then flush -> one word 0xAAC00000 with out_last=1, then a flush_done pulse.
REQ-041 Scenario: flush with fill=0 -> no out_valid; flush_done pulses 2 cycles after flush.
REQ-042 Scenario: size 55 -> overflow_err=1, fill unchanged; rst low mid-stream -> all outputs 0 asynchronously.
REQ-043 Scenario: with PACKER_BITCOUNT_EN defined, three groups of 20+3 bits -> total_bits=69.
